// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared widths, ALU function codes, FSM state encoding and a
//               helper that classifies multi-cycle ALU functions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

    localparam int ALU_WIDTH      = 8;
    localparam int ALU_FUNC_WIDTH = 5;

    // ALU function codes. Only mul/div/mod change arbiter behaviour; every
    // other code is forwarded untouched as a single-cycle operation.
    localparam int unsigned C_ALU_F_NOP   = 32'd0;
    localparam int unsigned C_ALU_F_ADD   = 32'd1;
    localparam int unsigned C_ALU_F_SUB   = 32'd2;
    localparam int unsigned C_ALU_F_MUL   = 32'd3;
    localparam int unsigned C_ALU_F_DIV   = 32'd4;
    localparam int unsigned C_ALU_F_MOD   = 32'd5;
    localparam int unsigned C_ALU_F_AND   = 32'd6;
    localparam int unsigned C_ALU_F_OR    = 32'd7;
    localparam int unsigned C_ALU_F_XOR   = 32'd8;
    localparam int unsigned C_ALU_F_NOT   = 32'd9;
    localparam int unsigned C_ALU_F_SHL   = 32'd10;
    localparam int unsigned C_ALU_F_SHR   = 32'd11;
    localparam int unsigned C_ALU_F_ROL   = 32'd12;
    localparam int unsigned C_ALU_F_ROR   = 32'd13;
    localparam int unsigned C_ALU_F_INC   = 32'd14;
    localparam int unsigned C_ALU_F_DEC   = 32'd15;
    localparam int unsigned C_ALU_F_NEG   = 32'd16;
    localparam int unsigned C_ALU_F_CMP   = 32'd17;
    localparam int unsigned C_ALU_F_PASSA = 32'd18;
    localparam int unsigned C_ALU_F_PASSB = 32'd19;
    localparam int unsigned C_ALU_F_MIN   = 32'd20;
    localparam int unsigned C_ALU_F_MAX   = 32'd21;
    localparam int unsigned C_ALU_F_ASR   = 32'd22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the functions whose ALU result needs MC_LAT cycles to settle.
    function automatic logic is_multicycle(input int unsigned f);
        return (f == C_ALU_F_MUL) || (f == C_ALU_F_DIV) || (f == C_ALU_F_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin grant: picks the first asserted
//               request at or after ptr, wrapping NUM_REQ-1 to 0. One-hot out.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             w_found;
    int               w_sum;
    logic [PTR_W-1:0] w_idx;

    // Walk the requesters starting from ptr and grant the first one found.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_sum = int'(ptr) + off;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between NUM_REQ requesters. One transaction in
//               flight: round-robin grant, operand latch, optional multi-cycle
//               settle wait, then a held response until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ALU_WIDTH      = alu_arbiter_pkg::ALU_WIDTH,
    parameter int ALU_FUNC_WIDTH = alu_arbiter_pkg::ALU_FUNC_WIDTH,
    parameter int MC_LAT         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*ALU_WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*ALU_WIDTH-1:0]      req_b,
    input  logic [NUM_REQ-1:0]                req_ci,
    input  logic [NUM_REQ*ALU_FUNC_WIDTH-1:0] req_f,
    output logic [NUM_REQ-1:0]                rsp_valid,
    input  logic [NUM_REQ-1:0]                rsp_ready,
    output logic [ALU_WIDTH-1:0]              rsp_s,
    output logic                              rsp_co,
    output logic [ALU_WIDTH-1:0]              alu_a,
    output logic [ALU_WIDTH-1:0]              alu_b,
    output logic                              alu_ci,
    output logic [ALU_FUNC_WIDTH-1:0]         alu_f,
    input  logic [ALU_WIDTH-1:0]              alu_s,
    input  logic                              alu_co
);

    import alu_arbiter_pkg::*;

    localparam int              PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] C_MC_LOAD = CNT_W'(MC_LAT - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [PTR_W-1:0]          r_rr_ptr;
    logic [PTR_W-1:0]          r_grant;
    logic [ALU_WIDTH-1:0]      r_a;
    logic [ALU_WIDTH-1:0]      r_b;
    logic                      r_ci;
    logic [ALU_FUNC_WIDTH-1:0] r_f;
    logic [CNT_W-1:0]          r_cnt;
    logic [ALU_WIDTH-1:0]      r_s;
    logic                      r_co;

    logic [NUM_REQ-1:0]        w_grant_oh;
    logic [PTR_W-1:0]          w_grant_idx;
    logic [ALU_FUNC_WIDTH-1:0] w_sel_f;
    logic                      w_accept;
    logic                      w_capture;
    logic                      w_rsp_done;
    logic [NUM_REQ-1:0]        w_rsp_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant_oh)
    );

    // One-hot grant to binary index used for operand selection.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_grant_idx = PTR_W'(i);
            end
        end
    end

    assign w_sel_f = req_f[w_grant_idx*ALU_FUNC_WIDTH +: ALU_FUNC_WIDTH];

    // Next-state and handshake decode for the IDLE/EXEC/RESP sequence.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[r_grant]) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Response strobe goes only to the requester that owns the transaction.
    always_comb begin
        w_rsp_valid = '0;
        if (r_state == ST_RESP) begin
            w_rsp_valid[r_grant] = 1'b1;
        end
    end

    // FSM state register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, settle counter, result capture and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ci     <= 1'b0;
            r_f      <= '0;
            r_cnt    <= '0;
            r_s      <= '0;
            r_co     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_grant_idx;
                r_a     <= req_a[w_grant_idx*ALU_WIDTH +: ALU_WIDTH];
                r_b     <= req_b[w_grant_idx*ALU_WIDTH +: ALU_WIDTH];
                r_ci    <= req_ci[w_grant_idx];
                r_f     <= w_sel_f;
                r_cnt   <= is_multicycle(32'(w_sel_f)) ? C_MC_LOAD : '0;
            end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                r_s  <= alu_s;
                r_co <= alu_co;
            end
            if (w_rsp_done) begin
                r_rr_ptr <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : (r_grant + PTR_W'(1));
            end
        end
    end

    // The ready strike is combinational, so it is masked directly by reset.
    assign req_ready = ((r_state == ST_IDLE) && !rst) ? w_grant_oh : '0;
    assign rsp_valid = w_rsp_valid;
    assign rsp_s     = r_s;
    assign rsp_co    = r_co;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_ci    = r_ci;
    assign alu_f     = r_f;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU
//               stub, round-robin reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int FW  = 5;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_ci, rsp_valid, rsp_ready;
    logic [N*W-1:0]  req_a, req_b;
    logic [N*FW-1:0] req_f;
    logic [W-1:0]    rsp_s, alu_a, alu_b, alu_s;
    logic            rsp_co, alu_ci, alu_co;
    logic [FW-1:0]   alu_f;

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ        (N),
        .ALU_WIDTH      (W),
        .ALU_FUNC_WIDTH (FW),
        .MC_LAT         (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .req_f     (req_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ci    (alu_ci),
        .alu_f     (alu_f),
        .alu_s     (alu_s),
        .alu_co    (alu_co)
    );

    // Behavioural ALU: returns {carry, sum}.
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic ci, input logic [4:0] f);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (f)
            5'd1:    return {1'b0, a} + {1'b0, b} + {8'b0, ci};
            5'd2:    return {1'b0, a} - {1'b0, b} - {8'b0, ci};
            5'd3:    return {|p[15:8], p[7:0]};
            5'd4:    return (b == 8'd0) ? 9'h0FF : {1'b0, a / b};
            5'd5:    return (b == 8'd0) ? {1'b0, a} : {1'b0, a % b};
            default: return {ci, a ^ b};
        endcase
    endfunction

    always_comb {alu_co, alu_s} = alu_model(alu_a, alu_b, alu_ci, alu_f);

    function automatic int rr_pick(input logic [N-1:0] vec, input int ptr);
        for (int off = 0; off < N; off++) begin
            if (vec[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic int exp_latency(input logic [4:0] f);
        return (f == 5'd3 || f == 5'd4 || f == 5'd5) ? LAT + 1 : 2;
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic [4:0] f);
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
        req_ci[i]         = ci;
        req_f[i*FW +: FW] = f;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    // Runs one transaction for requester exp_idx and checks grant, ALU drive,
    // latency, result, response hold under stall, and release.
    task automatic txn(input int exp_idx, input int exp_lat, input logic [4:0] f,
                       input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_res,
                       input int stall, input bit noise, input string tag);
        int           lat;
        int           guard;
        logic [N-1:0] saved;
        logic [N-1:0] exp_oh;
        exp_oh          = '0;
        exp_oh[exp_idx] = 1'b1;
        #1;
        guard = 0;
        while (req_ready === '0 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (req_ready !== exp_oh) begin
            failures++;
            $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, exp_oh);
        end
        @(posedge clk); #1;
        req_valid[exp_idx] = 1'b0;
        lat = 0;
        while (rsp_valid === '0 && lat < 40) begin
            @(negedge clk); #1;
            lat++;
            if (rsp_valid === '0) begin
                checks++;
                if (alu_f !== f || alu_a !== a || alu_b !== b || req_ready !== '0) begin
                    failures++;
                    $display("FAIL %s exec_drive: alu_f=%0d a=%h b=%h ready=%b expected f=%0d a=%h b=%h ready=0",
                             tag, alu_f, alu_a, alu_b, req_ready, f, a, b);
                end
            end
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        checks++;
        if (rsp_valid !== exp_oh) begin
            failures++;
            $display("FAIL %s rsp_valid: got %b expected %b", tag, rsp_valid, exp_oh);
        end
        checks++;
        if ({rsp_co, rsp_s} !== exp_res) begin
            failures++;
            $display("FAIL %s result: got co=%b s=%h expected co=%b s=%h",
                     tag, rsp_co, rsp_s, exp_res[8], exp_res[7:0]);
        end
        saved = req_valid;
        for (int k = 0; k < stall; k++) begin
            rsp_ready = N'($urandom) & ~exp_oh;
            if (noise) req_valid = N'($urandom);
            @(negedge clk); #1;
            checks++;
            if (rsp_valid !== exp_oh || {rsp_co, rsp_s} !== exp_res || req_ready !== '0) begin
                failures++;
                $display("FAIL %s stall[%0d]: rsp_valid=%b res=%h ready=%b expected %b %h 0",
                         tag, k, rsp_valid, {rsp_co, rsp_s}, req_ready, exp_oh, exp_res);
            end
        end
        req_valid = saved;
        rsp_ready = N'($urandom) | exp_oh;
        @(posedge clk); #1;
        rsp_ready = '0;
        checks++;
        if (rsp_valid !== '0) begin
            failures++;
            $display("FAIL %s release: rsp_valid=%b expected 0", tag, rsp_valid);
        end
        m_ptr = (exp_idx + 1) % N;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_a     = N*W'($urandom);
        req_b     = N*W'($urandom);
        req_ci    = '1;
        req_f     = '1;
        rsp_ready = '1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== '0) begin
            failures++; $display("FAIL reset_ready: got %b expected 0", req_ready);
        end
        checks++;
        if (rsp_valid !== '0) begin
            failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        checks++;
        if ({rsp_co, rsp_s} !== 9'd0) begin
            failures++; $display("FAIL reset_result: got %h expected 0", {rsp_co, rsp_s});
        end
        checks++;
        if ({alu_a, alu_b, alu_ci, alu_f} !== '0) begin
            failures++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_ci, alu_f});
        end
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        set_req(0, 8'h0F, 8'h01, 1'b0, 5'd1);
        txn(0, 2, 5'd1, 8'h0F, 8'h01, 9'h010, 0, 1'b0, "add");
    endtask

    task automatic test_round_robin();
        logic [7:0] a0, b0, a1, b1;
        do_reset();
        a0 = 8'($urandom); b0 = 8'($urandom);
        a1 = 8'($urandom); b1 = 8'($urandom);
        set_req(0, a0, b0, 1'b0, 5'd1);
        set_req(1, a1, b1, 1'b1, 5'd2);
        txn(0, 2, 5'd1, a0, b0, alu_model(a0, b0, 1'b0, 5'd1), 0, 1'b0, "rr_first");
        txn(1, 2, 5'd2, a1, b1, alu_model(a1, b1, 1'b1, 5'd2), 0, 1'b0, "rr_second");
        set_req(0, a0, b0, 1'b0, 5'd1);
        txn(0, 2, 5'd1, a0, b0, alu_model(a0, b0, 1'b0, 5'd1), 0, 1'b0, "rr_solo0");
        set_req(0, a0, b0, 1'b0, 5'd1);
        set_req(1, a1, b1, 1'b1, 5'd2);
        txn(1, 2, 5'd2, a1, b1, alu_model(a1, b1, 1'b1, 5'd2), 0, 1'b0, "rr_next1");
        txn(0, 2, 5'd1, a0, b0, alu_model(a0, b0, 1'b0, 5'd1), 0, 1'b0, "rr_next0");
    endtask

    task automatic test_mul_latency();
        @(negedge clk);
        set_req(1, 8'd3, 8'd5, 1'b0, 5'd3);
        txn(1, LAT + 1, 5'd3, 8'd3, 8'd5, 9'd15, 0, 1'b0, "mul");
    endtask

    task automatic test_stall();
        logic [7:0] a, b;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom);
        set_req(0, a, b, 1'b1, 5'd1);
        txn(0, 2, 5'd1, a, b, alu_model(a, b, 1'b1, 5'd1), 10, 1'b1, "stall");
    endtask

    task automatic test_reset_mid_exec();
        int guard;
        int seen;
        @(negedge clk);
        req_valid = '0;
        set_req(0, 8'd200, 8'd7, 1'b0, 5'd4);
        #1;
        guard = 0;
        while (req_ready === '0 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || {rsp_co, rsp_s} !== 9'd0 ||
            {alu_a, alu_b, alu_ci, alu_f} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: ready=%b rsp_valid=%b res=%h alu=%h expected all 0",
                     req_ready, rsp_valid, {rsp_co, rsp_s}, {alu_a, alu_b, alu_ci, alu_f});
        end
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;
        m_ptr     = 0;
        seen      = 0;
        repeat (8) begin
            @(negedge clk); #1;
            if (rsp_valid !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_rsp: rsp_valid seen %0d cycles expected 0", seen);
        end
        set_req(0, 8'd200, 8'd7, 1'b0, 5'd4);
        txn(0, LAT + 1, 5'd4, 8'd200, 8'd7, 9'd28, 0, 1'b0, "div_after_abort");
    endtask

    task automatic test_unknown_func();
        logic [7:0] a, b;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom);
        set_req(0, a, b, 1'b1, 5'd31);
        txn(0, 2, 5'd31, a, b, alu_model(a, b, 1'b1, 5'd31), 0, 1'b0, "func31");
    endtask

    task automatic test_random();
        logic [7:0]   ra [N];
        logic [7:0]   rb [N];
        logic         rc [N];
        logic [4:0]   rf [N];
        logic [N-1:0] vec;
        int           idx;
        for (int it = 0; it < 40; it++) begin
            vec       = N'($urandom_range(1, (1 << N) - 1));
            req_valid = '0;
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'($urandom);
                rb[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                rc[i] = 1'($urandom);
                rf[i] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(3, 5)) : 5'($urandom);
                if (vec[i]) set_req(i, ra[i], rb[i], rc[i], rf[i]);
            end
            idx = rr_pick(vec, m_ptr);
            txn(idx, exp_latency(rf[idx]), rf[idx], ra[idx], rb[idx],
                alu_model(ra[idx], rb[idx], rc[idx], rf[idx]),
                $urandom_range(0, 3), 1'($urandom), "random");
        end
        req_valid = '0;
    endtask

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        req_f     = '0;
        rsp_ready = '0;
        rst       = 1'b1;
        test_reset();
        test_single_add();
        test_round_robin();
        test_mul_latency();
        test_stall();
        test_reset_mid_exec();
        test_unknown_func();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
